gshare_bp: RTL
==============

GSHARE_BP -- requirements
Module: gshare_bp

Interface
REQ-001 SHALL have parameter CVA6Cfg: default config_pkg::cva6_cfg_empty; CVA6 configuration (VLEN, INSTR_PER_FETCH).
REQ-002 SHALL have parameters bht_update_t, bht_prediction_t, bp_metadata_t: default logic; CVA6 predictor structs, with metadata = {index, ghr, ctr}.
REQ-003 SHALL have parameter NR_ENTRIES: default 1024; total counters, power of two, multiple of INSTR_PER_FETCH.
REQ-004 SHALL have parameter HIST_BITS: default 8; global history length, 1..16.
REQ-005 SHALL have parameter CTR_BITS: default 2; saturating counter width, 1..4.
REQ-006 SHALL have port clk_i  in  1  clock.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port flush_bp_i  in  1  start table re-initialisation.
REQ-009 SHALL have port debug_mode_i  in  1  freeze predictor state.
REQ-010 SHALL have port vpc_i  in  VLEN  fetch PC.
REQ-011 SHALL have port ghr_push_i  in  2  {valid, taken}: speculative history push from frontend.
REQ-012 SHALL have port bht_update_i  in  bht_update_t  resolved branch {valid, pc, taken, metadata}.
REQ-013 SHALL have port bht_prediction_o  out  bht_prediction_t[INSTR_PER_FETCH]  per-slot prediction.
REQ-014 SHALL have port ready_o  out  1  high when not initialising.

Function
REQ-015 SHALL use NR_ROWS=NR_ENTRIES/INSTR_PER_FETCH, RB=log2(NR_ROWS), OFF=log2(INSTR_PER_FETCH)+1.
REQ-016 SHALL form row index = vpc_i[OFF+RB-1:OFF] XOR GHR, with GHR zero-extended or truncated to RB bits.
REQ-017 SHALL return predictions one cycle after vpc_i via registered RAM read.
REQ-018 Each slot s SHALL report valid=ready_o, taken=ctr MSB, metadata={index, GHR at lookup, ctr}.
REQ-019 SHALL shift GHR left by one on ghr_push_i.valid, inserting taken at bit 0.
REQ-020 SHALL write on bht_update_i.valid the counter at row metadata.index, slot pc[OFF-1:1], as sat(metadata.ctr+1) if taken else sat(metadata.ctr-1); no read-modify-write.
REQ-021 SHALL treat taken != metadata.ctr MSB as a mispredict: GHR <= {metadata.ghr[HIST_BITS-2:0], taken}.
REQ-022 SHALL give a mispredict restore priority over a same-cycle ghr_push_i; the push is dropped.
REQ-023 SHALL forward a write to the row and slot being read in the same cycle, so the next-cycle prediction shows the new value.
REQ-024 SHALL ignore updates and pushes while debug_mode_i=1; lookups continue.
REQ-025 FSM INIT: SHALL write weak-not-taken (2^(CTR_BITS-1)-1) to row cnt each cycle, cnt 0..NR_ROWS-1, then go to RUN.
REQ-026 FSM RUN: flush_bp_i SHALL clear GHR and cnt and enter INIT next cycle.
REQ-027 SHALL restart cnt at 0 on flush_bp_i during INIT.
REQ-028 SHALL drop updates and pushes during INIT and hold ready_o=0 and all valid=0.
REQ-029 Counters SHALL saturate at 0 and 2^CTR_BITS-1 without wrap.

Reset
REQ-030 Reset SHALL force GHR=0, cnt=0, state=INIT, ready_o=0, all prediction valid=0.
REQ-031 Reset mid-INIT SHALL restart the sweep from row 0.
REQ-032 RAM contents SHALL be unreset; INIT defines them after NR_ROWS cycles.

Structure
REQ-033 config_pkg SHALL hold GlobalPredictorSize and a new GlobalPredictorHistBits.
REQ-034 bp_metadata_t SHALL be built in the instantiating module from those fields.
REQ-035 One sub-module, gshare_ctr_ram: 1R1W per-slot bank of NR_ROWS x CTR_BITS with registered read, one instance per INSTR_PER_FETCH.

Verification
REQ-036 Reset release -> ready_o rises exactly 512 cycles later with defaults; every counter reads 1.
REQ-037 Three taken updates to index 5 slot 0 with carried ctr -> ctr 1->2->3->3, prediction taken.
REQ-038 GHR=0xA5 with vpc row 0x0F0 -> lookup index 0x055.
REQ-039 Same-cycle push(1) and mispredict update (metadata.ghr=0x3C, taken=0) -> GHR=0x78; push dropped.
REQ-040 flush_bp_i at INIT cycle 300 -> sweep restarts; ready_o rises 512 cycles after the flush.
REQ-041 debug_mode_i=1 with 10 updates and pushes -> GHR and RAM unchanged, checked against a shadow model.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration record shared by the frontend predictors.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned INSTR_PER_FETCH;
        int unsigned GlobalPredictorSize;
        int unsigned GlobalPredictorHistBits;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        VLEN:                    32,
        INSTR_PER_FETCH:         2,
        GlobalPredictorSize:     1024,
        GlobalPredictorHistBits: 8
    };

endpackage

// File: rtl/gshare_bp_pkg.sv
// Gshare predictor payload types, FSM encoding and counter arithmetic.
package gshare_bp_pkg;
    import config_pkg::*;

    localparam int unsigned GP_VLEN      = cva6_cfg_empty.VLEN;
    localparam int unsigned GP_IPF       = cva6_cfg_empty.INSTR_PER_FETCH;
    localparam int unsigned GP_ROW_BITS  = $clog2(cva6_cfg_empty.GlobalPredictorSize / GP_IPF);
    localparam int unsigned GP_HIST_BITS = cva6_cfg_empty.GlobalPredictorHistBits;
    localparam int unsigned GP_CTR_BITS  = 2;
    localparam int unsigned CTR_MAX_BITS = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [GP_ROW_BITS-1:0]  index;
        logic [GP_HIST_BITS-1:0] ghr;
        logic [GP_CTR_BITS-1:0]  ctr;
    } gshare_meta_t;

    typedef struct packed {
        logic               valid;
        logic [GP_VLEN-1:0] pc;
        logic               taken;
        gshare_meta_t       metadata;
    } gshare_update_t;

    typedef struct packed {
        logic         valid;
        logic         taken;
        gshare_meta_t metadata;
    } gshare_prediction_t;

    // Saturating +/-1 on a counter of 'bits' width, carried in a 4-bit container.
    function automatic logic [CTR_MAX_BITS-1:0] ctr_step(
        input logic [CTR_MAX_BITS-1:0] ctr,
        input logic                    up,
        input int unsigned             bits
    );
        logic [CTR_MAX_BITS-1:0] top;
        top = CTR_MAX_BITS'((32'd1 << bits) - 32'd1);
        if (up) begin
            return (ctr == top) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/gshare_ctr_ram.sv
// One slot's counter bank: 1R1W, registered read, write-to-read forwarding.
module gshare_ctr_ram #(
    parameter int unsigned NR_ROWS  = 512,
    parameter int unsigned CTR_BITS = 2,
    localparam int unsigned AW      = $clog2(NR_ROWS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [CTR_BITS-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [CTR_BITS-1:0] rdata
);

    logic [CTR_BITS-1:0] mem [NR_ROWS];

    // Contents are defined by the init sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch predictor: PC^GHR indexed saturating counters, one bank per fetch slot.
module gshare_bp
    import config_pkg::*;
    import gshare_bp_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg          = cva6_cfg_empty,
    parameter type         bht_update_t     = gshare_update_t,
    parameter type         bht_prediction_t = gshare_prediction_t,
    parameter type         bp_metadata_t    = gshare_meta_t,
    parameter int unsigned NR_ENTRIES       = 1024,
    parameter int unsigned HIST_BITS        = 8,
    parameter int unsigned CTR_BITS         = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_bp_i,
    input  logic                                          debug_mode_i,
    input  logic [CVA6Cfg.VLEN-1:0]                       vpc_i,
    input  logic [1:0]                                    ghr_push_i,
    input  bht_update_t                                   bht_update_i,
    output bht_prediction_t [CVA6Cfg.INSTR_PER_FETCH-1:0] bht_prediction_o,
    output logic                                          ready_o
);

    localparam int unsigned IPF     = CVA6Cfg.INSTR_PER_FETCH;
    localparam int unsigned NR_ROWS = NR_ENTRIES / IPF;
    localparam int unsigned RB      = $clog2(NR_ROWS);
    localparam int unsigned OFF     = $clog2(IPF) + 1;
    localparam int unsigned SB      = (IPF > 1) ? $clog2(IPF) : 1;
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
    localparam logic [RB-1:0]       LAST_ROW = RB'(NR_ROWS - 1);

    bp_state_e             state_q, state_d;
    logic [RB-1:0]         cnt_q, cnt_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  ready_q;
    logic [RB-1:0]         index_q;
    logic [HIST_BITS-1:0]  ghr_lk_q;

    logic                  init_we;
    logic                  upd_we;
    logic                  mispredict;
    logic [SB-1:0]         upd_slot;
    logic [RB-1:0]         lookup_index;
    logic [RB-1:0]         waddr;
    logic [CTR_BITS-1:0]   wdata;
    logic [IPF-1:0]        bank_we;
    logic [CTR_BITS-1:0]   rdata [IPF];
    logic                  unused_bits;

    assign unused_bits  = ^{vpc_i, bht_update_i.pc};
    assign lookup_index = RB'(vpc_i >> OFF) ^ RB'(ghr_q);
    assign upd_slot     = (IPF > 1) ? SB'(bht_update_i.pc >> 1) : '0;
    assign mispredict   = bht_update_i.taken != bht_update_i.metadata.ctr[CTR_BITS-1];
    assign ready_o      = ready_q;

    // Sweep / run control and global history management.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ghr_d   = ghr_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (flush_bp_i) begin
                    cnt_d = '0;
                    ghr_d = '0;
                end else if (cnt_q == LAST_ROW) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (flush_bp_i) begin
                    cnt_d   = '0;
                    ghr_d   = '0;
                    state_d = ST_INIT;
                end else if (!debug_mode_i) begin
                    // A resolved mispredict rebuilds history and overrides any push.
                    if (bht_update_i.valid && mispredict) begin
                        ghr_d = HIST_BITS'({bht_update_i.metadata.ghr, bht_update_i.taken});
                    end else if (ghr_push_i[1]) begin
                        ghr_d = HIST_BITS'({ghr_q, ghr_push_i[0]});
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
            ready_q <= (state_d == ST_RUN);
        end
    end

    // Lookup metadata travels alongside the registered RAM read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q  <= '0;
            ghr_lk_q <= '0;
        end else begin
            index_q  <= lookup_index;
            ghr_lk_q <= ghr_q;
        end
    end

    // Counter write port: init sweep or a blind write of the carried counter.
    always_comb begin
        upd_we  = (state_q == ST_RUN) && bht_update_i.valid && !debug_mode_i;
        waddr   = init_we ? cnt_q : RB'(bht_update_i.metadata.index);
        wdata   = init_we ? CTR_WNT
                          : CTR_BITS'(ctr_step(CTR_MAX_BITS'(bht_update_i.metadata.ctr),
                                               bht_update_i.taken, CTR_BITS));
        bank_we = '0;
        for (int s = 0; s < IPF; s++) begin
            bank_we[s] = init_we || (upd_we && (upd_slot == SB'(s)));
        end
    end

    for (genvar s = 0; s < IPF; s++) begin : g_bank
        gshare_ctr_ram #(
            .NR_ROWS  (NR_ROWS),
            .CTR_BITS (CTR_BITS)
        ) i_ram (
            .clk   (clk_i),
            .we    (bank_we[s]),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (lookup_index),
            .rdata (rdata[s])
        );
    end

    always_comb begin
        bp_metadata_t meta;
        for (int s = 0; s < IPF; s++) begin
            meta                         = '0;
            meta.index                   = index_q;
            meta.ghr                     = ghr_lk_q;
            meta.ctr                     = rdata[s];
            bht_prediction_o[s]          = '0;
            bht_prediction_o[s].valid    = ready_q;
            bht_prediction_o[s].taken    = rdata[s][CTR_BITS-1];
            bht_prediction_o[s].metadata = meta;
        end
    end

endmodule
